// File: rtl/cardet_pkg.sv
// -----------------------------------------------------------------------------
// cardet_pkg
// Shared definitions for the car-detection frame controller:
//   - state_e       : frame sequencer states
//   - STAT_*        : bit positions inside the sticky status byte
//   - BBOX_W        : packed box width {x_start,y_start,x_end,y_end}
//   - entry_width() : width of one stored result entry (box + confidence)
// -----------------------------------------------------------------------------
package cardet_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_REPORT  = 3'd4
   } state_e;

   localparam int STAT_SHORT_FRAME = 0;
   localparam int STAT_EARLY_DONE  = 1;
   localparam int STAT_TIMEOUT     = 2;
   localparam int STAT_MISSED_IRQ  = 3;
   localparam int STAT_OVERFLOW    = 4;
   localparam int STAT_ALARM       = 5;

   localparam int BBOX_W = 64;

   // One result entry is the packed box followed by its confidence.
   function automatic int entry_width(input int conf_w);
      return BBOX_W + conf_w;
   endfunction

endpackage

// File: rtl/cardet_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// cardet_det_if
// Detection bus from the SVM stage into the frame controller.
//   bbox_valid          : detection strobe
//   bbox_x/y_start/end  : detection box corners (16 bit each)
//   confidence          : SVM score, sampled with bbox_valid
//   done                : SVM end-of-frame pulse
// Modports: master = SVM side (drives), slave = frame controller (samples).
// -----------------------------------------------------------------------------
interface cardet_det_if #(
   parameter int CONFIDENCE_WIDTH = 44
);
   logic                        bbox_valid;
   logic [15:0]                 bbox_x_start;
   logic [15:0]                 bbox_y_start;
   logic [15:0]                 bbox_x_end;
   logic [15:0]                 bbox_y_end;
   logic [CONFIDENCE_WIDTH-1:0] confidence;
   logic                        done;

   modport master (
      output bbox_valid, bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end,
      output confidence, done
   );

   modport slave (
      input bbox_valid, bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end,
      input confidence, done
   );
endinterface

// File: rtl/cardet_result_bank.sv
// -----------------------------------------------------------------------------
// cardet_result_bank
// Two banks of DEPTH result entries. One bank is written by the sequencer
// while the other is frozen for host reads; the caller picks both banks.
// Ports:
//   clk, reset           : clock, synchronous active-low reset (read reg only)
//   wr_en/wr_bank/wr_addr/wr_data : write port
//   rd_bank/rd_addr      : read select
//   rd_data              : registered read data, one cycle latency
// -----------------------------------------------------------------------------
module cardet_result_bank #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 108
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic                     wr_bank,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_bank,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);
   // Bank number is the MSB of the flat index.
   logic [WIDTH-1:0] mem_q [2*DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[{wr_bank, wr_addr}] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[{rd_bank, rd_addr}];
      end
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/cardet_frame_ctrl.sv
// -----------------------------------------------------------------------------
// cardet_frame_ctrl
// Frame sequencer for the HOG -> SVM car detector. Arms on enable, gates one
// video frame into the detector, latches the SVM bias for that frame, waits
// for the SVM done pulse (with timeout) and publishes detections through a
// double-buffered result bank, a per-frame irq and sticky status flags.
// Ports:
//   clk, reset            : pixel clock, synchronous active-low reset
//   enable, single_shot   : run request / stop after one frame
//   bias_cfg -> bias_out  : bias, latched at frame start
//   irq_clear             : clears irq and status
//   vsync, de, frame_gate : video timing in, detector gate out
//   det                   : detection bus (boxes, confidence, done)
//   alarm_code            : HOG FIFO alarms
//   rd_addr/rd_bbox/rd_conf/det_count : host view of the frozen bank
//   busy, irq, status     : state not IDLE, frame-complete irq, sticky flags
// -----------------------------------------------------------------------------
module cardet_frame_ctrl
   import cardet_pkg::*;
#(
   parameter int IMAGE_WIDTH      = 64,
   parameter int IMAGE_HEIGHT     = 64,
   parameter int CONFIDENCE_WIDTH = 44,
   parameter int MAX_DETECTIONS   = 8,
   parameter int TIMEOUT_CYCLES   = 1048576
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              single_shot,
   input  logic [CONFIDENCE_WIDTH-1:0]       bias_cfg,
   input  logic                              irq_clear,
   input  logic                              vsync,
   input  logic                              de,
   output logic                              frame_gate,
   output logic [CONFIDENCE_WIDTH-1:0]       bias_out,
   cardet_det_if.slave                       det,
   input  logic [3:0]                        alarm_code,
   input  logic [$clog2(MAX_DETECTIONS)-1:0] rd_addr,
   output logic [63:0]                       rd_bbox,
   output logic [CONFIDENCE_WIDTH-1:0]       rd_conf,
   output logic [$clog2(MAX_DETECTIONS):0]   det_count,
   output logic                              busy,
   output logic                              irq,
   output logic [7:0]                        status
);
   localparam int AW      = $clog2(MAX_DETECTIONS);
   localparam int NPIX    = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int PIX_W   = $clog2(NPIX + 1);
   localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int ENTRY_W = entry_width(CONFIDENCE_WIDTH);

   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]      CNT_MAX  = (AW + 1)'(MAX_DETECTIONS);

   state_e                      state_q, state_d;
   logic                        vsync_q;
   logic                        gate_q, gate_d;
   logic [CONFIDENCE_WIDTH-1:0] bias_q, bias_d;
   logic [PIX_W-1:0]            pix_q, pix_d;
   logic [TO_W-1:0]             to_q, to_d;
   logic [AW:0]                 wr_cnt_q, wr_cnt_d;
   logic                        wr_bank_q, wr_bank_d;
   logic [AW:0]                 det_cnt_q, det_cnt_d;
   logic                        irq_q, irq_d;
   logic [7:0]                  status_q, status_d;

   logic                        vs_rise;
   logic                        pix_step;
   logic                        frame_full;
   logic                        bank_we;
   logic [7:0]                  set_flags;
   logic [ENTRY_W-1:0]          wr_entry;
   logic [ENTRY_W-1:0]          rd_entry;

   assign vs_rise    = vsync & ~vsync_q;
   assign pix_step   = de & gate_q;
   assign frame_full = pix_step && (pix_q == PIX_LAST);
   assign wr_entry   = {det.bbox_x_start, det.bbox_y_start, det.bbox_x_end,
                        det.bbox_y_end, det.confidence};

   always_comb begin
      state_d   = state_q;
      gate_d    = gate_q;
      bias_d    = bias_q;
      pix_d     = pix_q;
      to_d      = to_q;
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
      det_cnt_d = det_cnt_q;
      irq_d     = irq_clear ? 1'b0 : irq_q;
      set_flags = '0;
      bank_we   = 1'b0;

      // Detections are collected while the frame is in flight; once the
      // bank is full the count saturates and later boxes are dropped.
      if (det.bbox_valid && (state_q == ST_CAPTURE || state_q == ST_DRAIN)) begin
         if (wr_cnt_q < CNT_MAX) begin
            bank_we  = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
         end else begin
            set_flags[STAT_OVERFLOW] = 1'b1;
         end
      end

      if ((state_q != ST_IDLE) && (|alarm_code)) begin
         set_flags[STAT_ALARM] = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (vs_rise) begin
               state_d  = ST_CAPTURE;
               gate_d   = 1'b1;
               bias_d   = bias_cfg;
               wr_cnt_d = '0;
               pix_d    = '0;
            end
         end
         ST_CAPTURE: begin
            if (pix_step) pix_d = pix_q + 1'b1;
            // done wins over everything; it is only an error if the frame
            // has not been fully delivered yet.
            if (det.done) begin
               if (!frame_full) set_flags[STAT_EARLY_DONE] = 1'b1;
               gate_d  = 1'b0;
               state_d = ST_REPORT;
            end else if (frame_full) begin
               gate_d  = 1'b0;
               to_d    = '0;
               state_d = ST_DRAIN;
            end else if (vs_rise) begin
               set_flags[STAT_SHORT_FRAME] = 1'b1;
               gate_d  = 1'b0;
               to_d    = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (det.done) begin
               state_d = ST_REPORT;
            end else if (to_q == TO_LAST) begin
               set_flags[STAT_TIMEOUT] = 1'b1;
               state_d = ST_REPORT;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         ST_REPORT: begin
            wr_bank_d = ~wr_bank_q;
            det_cnt_d = wr_cnt_q;
            irq_d     = 1'b1;
            if (irq_q) set_flags[STAT_MISSED_IRQ] = 1'b1;
            state_d   = (enable && !single_shot) ? ST_ARMED : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      status_d = (irq_clear ? 8'h00 : status_q) | set_flags;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         vsync_q   <= 1'b0;
         gate_q    <= 1'b0;
         bias_q    <= '0;
         pix_q     <= '0;
         to_q      <= '0;
         wr_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
         det_cnt_q <= '0;
         irq_q     <= 1'b0;
         status_q  <= '0;
      end else begin
         state_q   <= state_d;
         vsync_q   <= vsync;
         gate_q    <= gate_d;
         bias_q    <= bias_d;
         pix_q     <= pix_d;
         to_q      <= to_d;
         wr_cnt_q  <= wr_cnt_d;
         wr_bank_q <= wr_bank_d;
         det_cnt_q <= det_cnt_d;
         irq_q     <= irq_d;
         status_q  <= status_d;
      end
   end

   // The host always reads the bank that is not being written.
   cardet_result_bank #(
      .DEPTH (MAX_DETECTIONS),
      .WIDTH (ENTRY_W)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bank_we),
      .wr_bank (wr_bank_q),
      .wr_addr (wr_cnt_q[AW-1:0]),
      .wr_data (wr_entry),
      .rd_bank (~wr_bank_q),
      .rd_addr (rd_addr),
      .rd_data (rd_entry)
   );

   assign frame_gate = gate_q;
   assign bias_out   = bias_q;
   assign rd_bbox    = rd_entry[ENTRY_W-1 -: 64];
   assign rd_conf    = rd_entry[CONFIDENCE_WIDTH-1:0];
   assign det_count  = det_cnt_q;
   assign busy       = (state_q != ST_IDLE);
   assign irq        = irq_q;
   assign status     = status_q;
endmodule
